// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between IF/ID and the immediate generator output.
// slave is the generator side, master is the upstream/downstream side.
interface imm_gen_stage_if #(
  parameter int TAG_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_instr, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport master (
    output in_valid, in_instr, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator with a two-entry skid buffer.
// Immediates are extended at accept time and leave in FIFO order.
module imm_gen_stage #(
  parameter int TAG_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_stage_if.slave bus
);

  logic [63:0]      new_imm;
  logic             new_err;

  logic             main_valid;
  logic [63:0]      main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_err;

  logic             skid_valid;
  logic [63:0]      skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic             accept;
  logic             drain;

  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    unique case (1'b1)
      (bus.in_sel == 3'd0):
        new_imm = {52'd0, bus.in_instr[21:10]};
      (bus.in_sel == 3'd1):
        new_imm = {{55{bus.in_instr[20]}},
                   bus.in_instr[20:12]};
      (bus.in_sel == 3'd2):
        new_imm = {{36{bus.in_instr[25]}},
                   bus.in_instr[25:0], 2'b00};
      (bus.in_sel == 3'd3):
        new_imm = {{43{bus.in_instr[23]}},
                   bus.in_instr[23:5], 2'b00};
      // halfword index times 16 gives the MOVW shift
      (bus.in_sel == 3'd4):
        new_imm = {48'd0, bus.in_instr[20:5]}
                  << {bus.in_instr[22:21], 4'd0};
      default:
        new_err = 1'b1;
    endcase
  end

  assign accept = bus.in_valid & ~skid_valid;
  assign drain  = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_imm   <= new_imm;
        main_tag   <= bus.in_tag;
        main_err   <= new_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= new_imm;
      skid_tag   <= bus.in_tag;
      skid_err   <= new_err;
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_imm   = main_imm;
  assign bus.out_tag   = main_tag;
  assign bus.out_err   = main_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: arithmetic reference model,
// directed format/backpressure/flush/reset cases, then random traffic.
module tb_imm_gen_stage;

  logic clk;
  logic reset;
  logic flush;

  imm_gen_stage_if #(.TAG_W(64)) b ();

  imm_gen_stage #(.TAG_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b.slave)
  );

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_imm, prev_tag;
  logic        prev_err;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: field value from shifts/modulo, sign by subtracting 2^w
  function automatic void ref_imm(input logic [31:0] instr,
                                  input logic [2:0] sel,
                                  output logic [63:0] imm,
                                  output logic err);
    longint unsigned u;
    longint v;
    longint unsigned hw;
    u = 64'(instr);
    imm = 0;
    err = 1'b0;
    case (sel)
      3'd0: imm = (u >> 10) % 4096;
      3'd1: begin
        v = longint'((u >> 12) % 512);
        if (v >= 256) v -= 512;
        imm = 64'(v);
      end
      3'd2: begin
        v = longint'(u % 67108864);
        if (v >= 33554432) v -= 67108864;
        imm = 64'(v * 4);
      end
      3'd3: begin
        v = longint'((u >> 5) % 524288);
        if (v >= 262144) v -= 524288;
        imm = 64'(v * 4);
      end
      3'd4: begin
        hw = (u >> 21) % 4;
        imm = ((u >> 5) % 65536) * (64'd1 << (16 * hw));
      end
      default: err = 1'b1;
    endcase
  endfunction

  // Recorder: expected entry pushed on every real accept
  always @(negedge clk) begin
    exp_t e;
    if (!reset) sb.delete();
    else if (flush) sb.delete();
    else if (b.in_valid && b.in_ready) begin
      ref_imm(b.in_instr, b.in_sel, e.imm, e.err);
      e.tag = b.in_tag;
      sb.push_back(e);
    end
  end

  // Monitor: pops on every drain, checks stability while stalled
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {63'd0, b.out_valid}, 64'd1);
        chk("hold_imm", b.out_imm, prev_imm);
        chk("hold_tag", b.out_tag, prev_tag);
        chk("hold_err", {63'd0, b.out_err}, {63'd0, prev_err});
      end
      if (!flush && b.out_valid && b.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", b.out_tag, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_imm", b.out_imm, e.imm);
          chk("sb_tag", b.out_tag, e.tag);
          chk("sb_err", {63'd0, b.out_err}, {63'd0, e.err});
        end
      end
      hold_prev = !flush && b.out_valid && !b.out_ready;
      prev_imm = b.out_imm;
      prev_tag = b.out_tag;
      prev_err = b.out_err;
    end
  end

  task automatic set_in(input logic [31:0] instr, input logic [2:0] sel,
                        input logic [63:0] tag);
    b.in_valid = 1'b1;
    b.in_instr = instr;
    b.in_sel   = sel;
    b.in_tag   = tag;
  endtask

  // Presents a word until accepted; returns at edge+1 with in_valid low
  task automatic send(input logic [31:0] instr, input logic [2:0] sel,
                      input logic [63:0] tag);
    set_in(instr, sel, tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b.in_ready && !flush) begin
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 expected 1");
    b.in_valid = 1'b0;
  endtask

  task automatic direct(input string name, input logic [31:0] instr,
                        input logic [2:0] sel, input logic [63:0] exp_imm,
                        input logic exp_err);
    logic [63:0] tag;
    tag = {$urandom, $urandom};
    send(instr, sel, tag);
    chk({name, "_valid"}, {63'd0, b.out_valid}, 64'd1);
    chk({name, "_imm"}, b.out_imm, exp_imm);
    chk({name, "_err"}, {63'd0, b.out_err}, {63'd0, exp_err});
    chk({name, "_tag"}, b.out_tag, tag);
  endtask

  task automatic reset_state(input string name);
    chk({name, "_out_valid"}, {63'd0, b.out_valid}, 64'd0);
    chk({name, "_in_ready"}, {63'd0, b.in_ready}, 64'd1);
    chk({name, "_out_imm"}, b.out_imm, 64'd0);
    chk({name, "_out_tag"}, b.out_tag, 64'd0);
    chk({name, "_out_err"}, {63'd0, b.out_err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] ta, tb_, tc, td;
    clk = 1'b0;
    reset = 1'b0;
    flush = 1'b0;
    b.in_valid = 1'b0;
    b.in_instr = '0;
    b.in_sel = '0;
    b.in_tag = '0;
    b.out_ready = 1'b0;
    #1;
    reset_state("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    b.out_ready = 1'b1;

    ins = $urandom; ins[20:12] = 9'h1F3;
    direct("daddr", ins, 3'd1, 64'hFFFF_FFFF_FFFF_FFF3, 1'b0);
    ins = $urandom; ins[21:10] = 12'hFFF;
    direct("alu", ins, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0);
    ins = $urandom; ins[20:5] = 16'hBEEF; ins[22:21] = 2'd2;
    direct("movw", ins, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0);
    ins = $urandom; ins[25:0] = 26'h3FF_FFFF;
    direct("br", ins, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    ins = $urandom; ins[23:5] = 19'h00010;
    direct("cbr", ins, 3'd3, 64'h0000_0000_0000_0040, 1'b0);
    ins = $urandom;
    direct("rsvd", ins, 3'd6, 64'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: A main, B skid, C held upstream
    ta = {$urandom, $urandom};
    tb_ = {$urandom, $urandom};
    tc = {$urandom, $urandom};
    b.out_ready = 1'b0;
    set_in($urandom, 3'($urandom_range(0, 4)), ta);
    @(posedge clk); #1;
    chk("bp_a_valid", {63'd0, b.out_valid}, 64'd1);
    chk("bp_a_tag", b.out_tag, ta);
    set_in($urandom, 3'($urandom_range(0, 7)), tb_);
    @(posedge clk); #1;
    chk("bp_ready_low", {63'd0, b.in_ready}, 64'd0);
    set_in($urandom, 3'($urandom_range(0, 7)), tc);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_stall_tag", b.out_tag, ta);
      chk("bp_stall_ready", {63'd0, b.in_ready}, 64'd0);
    end
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_tag", b.out_tag, tb_);
    chk("bp_ready_back", {63'd0, b.in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("bp_c_tag", b.out_tag, tc);
    chk("bp_c_valid", {63'd0, b.out_valid}, 64'd1);
    b.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", {63'd0, b.out_valid}, 64'd0);

    // flush with both entries full and C presented
    b.out_ready = 1'b0;
    set_in($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    @(posedge clk); #1;
    set_in($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    @(posedge clk); #1;
    set_in($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b.in_valid = 1'b0;
    chk("fl_valid", {63'd0, b.out_valid}, 64'd0);
    chk("fl_ready", {63'd0, b.in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("fl_no_c", {63'd0, b.out_valid}, 64'd0);
    b.out_ready = 1'b1;
    td = {$urandom, $urandom};
    send($urandom, 3'($urandom_range(0, 7)), td);
    chk("fl_d_valid", {63'd0, b.out_valid}, 64'd1);
    chk("fl_d_tag", b.out_tag, td);
    @(posedge clk); #1;

    // asynchronous reset mid-transfer
    b.out_ready = 1'b0;
    set_in($urandom, 3'($urandom_range(0, 4)), {$urandom, $urandom});
    @(posedge clk); #1;
    set_in($urandom, 3'($urandom_range(0, 4)), {$urandom, $urandom});
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    chk("ar_full", {63'd0, b.in_ready}, 64'd0);
    #1 reset = 1'b0;
    #1;
    reset_state("async_rst");
    b.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    ins = $urandom; ins[21:10] = 12'h5A5;
    direct("post_rst", ins, 3'd0, 64'h5A5, 1'b0);

    // random traffic against the scoreboard
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      b.out_ready = ($urandom_range(0, 99) < 65);
      flush = ($urandom_range(0, 99) < 3);
      b.in_valid = ($urandom_range(0, 99) < 70);
      b.in_instr = $urandom;
      b.in_sel = 3'($urandom_range(0, 7));
      b.in_tag = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    flush = 1'b0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("end_idle", {63'd0, b.out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Decode-stage immediate generator for the pipelined core. It accepts an instruction word plus a tag (the PC) from the IF/ID boundary under a valid/ready handshake. It extracts the immediate field selected by the control unit and sign- or zero-extends it to 64 bits, shifting it where the format requires. The result is presented to the ID/EX boundary through a two-entry skid buffer with flush support, so upstream and downstream stalls never drop or reorder immediates.

Parameters:
TAG_W, 64, width of the pass-through tag (PC of the instruction).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
flush  input  1  synchronous pipeline flush (branch mispredict/taken branch).
in_valid  input  1  instruction word and select are valid.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  instruction word.
in_sel  input  3  immediate format select.
in_tag  input  TAG_W  tag carried with the instruction.
out_valid  output  1  out_imm/out_tag/out_err are valid.
out_ready  input  1  downstream accepts this cycle.
out_imm  output  64  extended immediate.
out_tag  output  TAG_W  tag of the instruction that produced out_imm.
out_err  output  1  in_sel was a reserved encoding.

Behaviour:
- Format select and extension, computed combinationally from in_instr/in_sel at accept time:
  - 0 ALU_IMM: instr[21:10], zero-extended.
  - 1 DADDR: instr[20:12], sign-extended from bit 8.
  - 2 BR: instr[25:0], sign-extended from bit 25, then shifted left 2.
  - 3 CBR: instr[23:5], sign-extended from bit 18, then shifted left 2.
  - 4 MOVW: instr[20:5], zero-extended, then shifted left by 16*instr[22:21].
  - 5-7 reserved: imm = 0 and err = 1. For all other encodings err = 0.
- Shifts discard bits above bit 63. No wrap-around.
- Storage: main register (out_*) and skid register (skid_valid, imm, tag, err).
- in_ready = !skid_valid. It is a pure register output with no combinational path from out_ready.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Next-state rules, evaluated when flush = 0:
  - Main empty or draining, skid empty: on accept, the new entry loads main; otherwise out_valid = 0 after a drain.
  - Main full and not draining: on accept, the new entry loads the skid.
  - Main draining and skid full: the skid moves to main and the skid clears. No accept is possible because in_ready = 0.
  - Main full, not draining, skid full: hold all state.
- Latency: an accepted word appears on out_* the next cycle when the buffer is empty. Throughput is one per cycle under continuous out_ready.
- Order is strictly FIFO. Entries are never duplicated or dropped.
- out_imm, out_tag and out_err stay stable while out_valid & !out_ready.
- flush: on the next edge out_valid = 0 and skid_valid = 0, so in_ready = 1. Flush overrides an accept or drain in the same cycle; the in_* word is discarded.
- Reset asserted, at any time including mid-transfer: immediately out_valid = 0, skid_valid = 0, in_ready = 1, out_imm = 0, out_tag = 0, out_err = 0. Normal operation starts on the first edge after deassertion.

Test Plan:
- DADDR: sel=1, instr[20:12]=9'h1F3, out_ready=1 -> next cycle out_imm=64'hFFFF_FFFF_FFFF_FFF3, out_err=0, out_tag equals in_tag.
- ALU_IMM and MOVW:
  - sel=0, instr[21:10]=12'hFFF -> out_imm=64'h0000_0000_0000_0FFF.
  - sel=4, imm16=16'hBEEF, hw=2 -> out_imm=64'h0000_BEEF_0000_0000.
- Branch formats:
  - sel=2, instr[25:0]=26'h3FF_FFFF -> out_imm=64'hFFFF_FFFF_FFFF_FFFC.
  - sel=3, instr[23:5]=19'h00010 -> out_imm=64'h0000_0000_0000_0040.
  - sel=6 -> out_imm=0, out_err=1.
- Backpressure: out_ready=0, present words A,B,C back-to-back.
  - A and B are accepted; in_ready=0 from the cycle after B.
  - C is held upstream while out_* stays on A.
  - Raise out_ready -> outputs A,B,C on consecutive cycles; in_ready returns to 1 one cycle after A drains.
- Flush with the buffer full (A in main, B in skid) and in_valid=1 with C -> next cycle out_valid=0, in_ready=1; C is never output; a following D emerges one cycle after acceptance.
- Reset: assert reset asynchronously with both entries full and out_ready=0 -> out_valid=0 and in_ready=1 immediately, with no clock edge; after deassertion a new word flows with one-cycle latency.
